ex_hazard_controller: RTL and testbench
=======================================

# ex_hazard_controller

Hazard and sequencing controller for the EX-stage datapath of the pipelined core. It generates the two forwarding-mux selects for the EX operand paths. It detects load-use hazards and holds the front end for a configurable number of cycles. It also sequences the front-end flush when EX resolves a taken jump or branch. Saturating event counters are kept for performance debug.

## Interface
- RegBits, 5, register-index width
- StallCycles, 1, cycles the front end is held per load-use hazard (≥1)
- CounterBits, 16, width of each event counter
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ID_Rs, ID_Rt  in  RegBits each  source registers of the instruction in ID
- ID_UsesRs, ID_UsesRt  in  1 each  the ID instruction reads that source
- EX_Rs, EX_Rt  in  RegBits each  source registers of the instruction in EX
- EX_WriteReg  in  RegBits  destination of the instruction in EX
- EX_MemRead  in  1  the instruction in EX is a load
- MEM_WriteReg, MEM_RegWrite  in  RegBits, 1  destination and write enable in MEM
- WB_WriteReg, WB_RegWrite  in  RegBits, 1  destination and write enable in WB
- JumpOrBranchControll  in  1  EX redirect taken this cycle
- ForwardA, ForwardB  out  2 each  operand selects: 0 register file, 1 WB data, 2 MEM ALU result
- PCWrite  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- ID_EX_Bubble  out  1  load a NOP into ID/EX
- IF_ID_Flush, ID_EX_Flush  out  1 each  squash the wrong-path instructions
- StallCount, FlushCount  out  CounterBits each  saturating event counters

## Operation
- Forwarding is combinational and is applied separately to A (EX_Rs) and B (EX_Rt).
  - Select 2 if MEM_RegWrite, MEM_WriteReg≠0, and MEM_WriteReg equals the source.
  - Otherwise select 1 if WB_RegWrite, WB_WriteReg≠0, and WB_WriteReg equals the source.
  - Otherwise select 0. MEM has priority over WB.
- Hazard is asserted when EX_MemRead, EX_WriteReg≠0, and either (ID_UsesRs and ID_Rs=EX_WriteReg) or (ID_UsesRt and ID_Rt=EX_WriteReg).
- States: RUN, STALL, FLUSH. There is also a stall down-counter of width ceil(log2(StallCycles))+1.
- RUN:
  - If JumpOrBranchControll: IF_ID_Flush=ID_EX_Flush=1, go to FLUSH. Flush has priority over Hazard.
  - Else if Hazard: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. If StallCycles>1, load the counter with StallCycles−1 and go to STALL; otherwise stay in RUN.
  - Else: PCWrite=1, IF_ID_Write=1, and all other control outputs 0.
- STALL:
  - Hold PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 and decrement the counter.
  - Go to RUN in the cycle the counter reaches 0 after decrementing.
  - JumpOrBranchControll is not expected here (EX holds a bubble). If it is asserted anyway, the flush wins: assert both flushes and go to FLUSH.
- FLUSH:
  - One cycle: PCWrite=1, IF_ID_Write=1. Hazard detection is masked because ID holds a squashed instruction.
  - A new JumpOrBranchControll in this cycle asserts both flushes again and stays in FLUSH.
  - Otherwise return to RUN.
- Counters:
  - StallCount increments in every cycle with ID_EX_Bubble=1.
  - FlushCount increments once per cycle with IF_ID_Flush=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Forward and hazard outputs are combinational, with zero-cycle latency from their inputs. The state, the stall counter and the event counters are registered on the rising edge of clk.
- A load-use hazard detected in cycle T holds the front end for cycles T..T+StallCycles−1. Normal flow resumes in T+StallCycles.
- A redirect in cycle T flushes in T. Hazard is masked in T+1.
- While reset=1, outputs are forced as follows:
  - ForwardA=ForwardB=0
  - PCWrite=1, IF_ID_Write=1
  - ID_EX_Bubble=0, IF_ID_Flush=0, ID_EX_Flush=0
  - StallCount=FlushCount=0
  - state=RUN, stall counter=0
- Reset asserted mid-STALL or mid-FLUSH aborts immediately and asynchronously to the values above. The first cycle after deassertion is RUN.

## Test plan
- Forwarding: EX_Rs=EX_Rt=3; MEM_WriteReg=3 with MEM_RegWrite=1; WB_WriteReg=3 with WB_RegWrite=1 -> ForwardA=ForwardB=2. Drop MEM_RegWrite -> both 1. Set all destinations to 0 -> both 0.
- Load-use, StallCycles=1: EX_MemRead=1, EX_WriteReg=8, ID_Rt=8, ID_UsesRt=1 -> exactly one cycle with PCWrite=0 and ID_EX_Bubble=1, then PCWrite=1; StallCount=1.
- Load-use, StallCycles=3: same stimulus, hazard inputs cleared after the first cycle -> three consecutive bubble cycles, then RUN; StallCount=3.
- Redirect: JumpOrBranchControll=1 in the same cycle as a Hazard match -> both flushes=1, ID_EX_Bubble=0. Next cycle, with the Hazard match still present -> no stall; FlushCount=1.
- Back-to-back redirects in consecutive cycles -> flushes asserted in both cycles; FlushCount=2.
- Reset asserted in the second cycle of a 3-cycle stall -> PCWrite=1 and StallCount=0 immediately. After release, no bubble unless Hazard recurs. A counter preset near all-ones (CounterBits=2, five stalls) holds at 3.

Source files
------------

// File: rtl/ex_hazard_controller.sv
// EX-stage hazard and sequencing controller: operand forwarding selects,
// load-use stall sequencing, redirect flush sequencing and saturating
// event counters for performance debug.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal flow; redirect flushes, load-use hazard stalls
// ST_STALL | front end held; down-counter runs out the remaining cycles
// ST_FLUSH | one cycle after a redirect; hazard masked (ID is squashed)
module ex_hazard_controller #(
  parameter int RegBits     = 5,
  parameter int StallCycles = 1,
  parameter int CounterBits = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [RegBits-1:0]     i_id_rs,
  input  logic [RegBits-1:0]     i_id_rt,
  input  logic                   i_id_uses_rs,
  input  logic                   i_id_uses_rt,
  input  logic [RegBits-1:0]     i_ex_rs,
  input  logic [RegBits-1:0]     i_ex_rt,
  input  logic [RegBits-1:0]     i_ex_write_reg,
  input  logic                   i_ex_mem_read,
  input  logic [RegBits-1:0]     i_mem_write_reg,
  input  logic                   i_mem_reg_write,
  input  logic [RegBits-1:0]     i_wb_write_reg,
  input  logic                   i_wb_reg_write,
  input  logic                   i_jump_or_branch,
  output logic [1:0]             o_forward_a,
  output logic [1:0]             o_forward_b,
  output logic                   o_pc_write,
  output logic                   o_if_id_write,
  output logic                   o_id_ex_bubble,
  output logic                   o_if_id_flush,
  output logic                   o_id_ex_flush,
  output logic [CounterBits-1:0] o_stall_count,
  output logic [CounterBits-1:0] o_flush_count
);

  localparam int SCW = $clog2(StallCycles) + 1;
  localparam logic [SCW-1:0] STALL_LOAD = SCW'(StallCycles - 1);
  localparam bit MULTI_STALL = (StallCycles > 1);

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_t;

  state_t                 r_state;
  logic [SCW-1:0]         r_stall_cnt;
  logic [CounterBits-1:0] r_stall_count;
  logic [CounterBits-1:0] r_flush_count;

  state_t         w_state_nxt;
  logic [SCW-1:0] w_stall_cnt_nxt;
  logic [SCW-1:0] w_stall_cnt_dec;
  logic           w_hazard;
  logic           w_pc_write;
  logic           w_if_id_write;
  logic           w_bubble;
  logic           w_flush;
  logic           w_mem_hit_a, w_mem_hit_b, w_wb_hit_a, w_wb_hit_b;

  // Forwarding match terms; register 0 never forwards.
  always_comb begin
    w_mem_hit_a = i_mem_reg_write && (i_mem_write_reg != '0) && (i_mem_write_reg == i_ex_rs);
    w_mem_hit_b = i_mem_reg_write && (i_mem_write_reg != '0) && (i_mem_write_reg == i_ex_rt);
    w_wb_hit_a  = i_wb_reg_write && (i_wb_write_reg != '0) && (i_wb_write_reg == i_ex_rs);
    w_wb_hit_b  = i_wb_reg_write && (i_wb_write_reg != '0) && (i_wb_write_reg == i_ex_rt);
  end

  // Operand selects: MEM result is newer than WB, so it wins.
  always_comb begin
    o_forward_a = 2'd0;
    o_forward_b = 2'd0;
    if (!i_reset) begin
      if (w_mem_hit_a)     o_forward_a = 2'd2;
      else if (w_wb_hit_a) o_forward_a = 2'd1;
      if (w_mem_hit_b)     o_forward_b = 2'd2;
      else if (w_wb_hit_b) o_forward_b = 2'd1;
    end
  end

  // Load-use hazard against either source the ID instruction actually reads.
  always_comb begin
    w_hazard = i_ex_mem_read && (i_ex_write_reg != '0) &&
               ((i_id_uses_rs && (i_id_rs == i_ex_write_reg)) ||
                (i_id_uses_rt && (i_id_rt == i_ex_write_reg)));
  end

  // Next-state and control decode; controls react in the same cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_stall_cnt_dec = r_stall_cnt - 1'b1;
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_bubble        = 1'b0;
    w_flush         = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_jump_or_branch) begin
          w_flush     = 1'b1;
          w_state_nxt = ST_FLUSH;
        end else if (w_hazard) begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_bubble      = 1'b1;
          if (MULTI_STALL) begin
            w_stall_cnt_nxt = STALL_LOAD;
            w_state_nxt     = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (i_jump_or_branch) begin
          w_flush         = 1'b1;
          w_stall_cnt_nxt = '0;
          w_state_nxt     = ST_FLUSH;
        end else begin
          w_pc_write      = 1'b0;
          w_if_id_write   = 1'b0;
          w_bubble        = 1'b1;
          w_stall_cnt_nxt = w_stall_cnt_dec;
          if (w_stall_cnt_dec == '0) w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (i_jump_or_branch) w_flush = 1'b1;
        else                  w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_stall_cnt_nxt = '0;
      end
    endcase
    if (i_reset) begin
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
      w_bubble      = 1'b0;
      w_flush       = 1'b0;
    end
  end

  // State and stall down-counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  // Saturating event counters; they stick at all-ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_bubble && (r_stall_count != '1)) r_stall_count <= r_stall_count + 1'b1;
      if (w_flush && (r_flush_count != '1))  r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign o_pc_write     = w_pc_write;
  assign o_if_id_write  = w_if_id_write;
  assign o_id_ex_bubble = w_bubble;
  assign o_if_id_flush  = w_flush;
  assign o_id_ex_flush  = w_flush;
  assign o_stall_count  = r_stall_count;
  assign o_flush_count  = r_flush_count;

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Directed bench: three controller instances share one stimulus bus
// (StallCycles=1, StallCycles=3, and a 2-bit counter instance).
module tb_ex_hazard_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr, mem_wr, wb_wr;
  logic       id_urs, id_urt, ex_mr, mem_rw, wb_rw, jb;

  logic [1:0]  fa_1, fb_1, fa_3, fb_3, fa_s, fb_s;
  logic        pc_1, ifw_1, bub_1, iff_1, exf_1;
  logic        pc_3, ifw_3, bub_3, iff_3, exf_3;
  logic        pc_s, ifw_s, bub_s, iff_s, exf_s;
  logic [15:0] sc_1, fc_1, sc_3, fc_3;
  logic [1:0]  sc_s, fc_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_hazard_controller #(.RegBits(5), .StallCycles(1), .CounterBits(16)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(id_urs), .i_id_uses_rt(id_urt), .i_ex_rs(ex_rs), .i_ex_rt(ex_rt),
    .i_ex_write_reg(ex_wr), .i_ex_mem_read(ex_mr), .i_mem_write_reg(mem_wr),
    .i_mem_reg_write(mem_rw), .i_wb_write_reg(wb_wr), .i_wb_reg_write(wb_rw),
    .i_jump_or_branch(jb), .o_forward_a(fa_1), .o_forward_b(fb_1),
    .o_pc_write(pc_1), .o_if_id_write(ifw_1), .o_id_ex_bubble(bub_1),
    .o_if_id_flush(iff_1), .o_id_ex_flush(exf_1),
    .o_stall_count(sc_1), .o_flush_count(fc_1));

  ex_hazard_controller #(.RegBits(5), .StallCycles(3), .CounterBits(16)) u_dut3 (
    .i_clk(clk), .i_reset(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(id_urs), .i_id_uses_rt(id_urt), .i_ex_rs(ex_rs), .i_ex_rt(ex_rt),
    .i_ex_write_reg(ex_wr), .i_ex_mem_read(ex_mr), .i_mem_write_reg(mem_wr),
    .i_mem_reg_write(mem_rw), .i_wb_write_reg(wb_wr), .i_wb_reg_write(wb_rw),
    .i_jump_or_branch(jb), .o_forward_a(fa_3), .o_forward_b(fb_3),
    .o_pc_write(pc_3), .o_if_id_write(ifw_3), .o_id_ex_bubble(bub_3),
    .o_if_id_flush(iff_3), .o_id_ex_flush(exf_3),
    .o_stall_count(sc_3), .o_flush_count(fc_3));

  ex_hazard_controller #(.RegBits(5), .StallCycles(1), .CounterBits(2)) u_sat (
    .i_clk(clk), .i_reset(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(id_urs), .i_id_uses_rt(id_urt), .i_ex_rs(ex_rs), .i_ex_rt(ex_rt),
    .i_ex_write_reg(ex_wr), .i_ex_mem_read(ex_mr), .i_mem_write_reg(mem_wr),
    .i_mem_reg_write(mem_rw), .i_wb_write_reg(wb_wr), .i_wb_reg_write(wb_rw),
    .i_jump_or_branch(jb), .o_forward_a(fa_s), .o_forward_b(fb_s),
    .o_pc_write(pc_s), .o_if_id_write(ifw_s), .o_id_ex_bubble(bub_s),
    .o_if_id_flush(iff_s), .o_id_ex_flush(exf_s),
    .o_stall_count(sc_s), .o_flush_count(fc_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_urs = 0; id_urt = 0;
    ex_rs = 0; ex_rt = 0; ex_wr = 0; ex_mr = 0;
    mem_wr = 0; mem_rw = 0; wb_wr = 0; wb_rw = 0; jb = 0;
  endtask

  task automatic set_hazard();
    ex_mr = 1; ex_wr = 5'd8; id_rt = 5'd8; id_urt = 1;
  endtask

  task automatic clr_hazard();
    ex_mr = 0; ex_wr = 0; id_rt = 0; id_urt = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    ex_rs = 3; ex_rt = 3; mem_wr = 3; mem_rw = 1; set_hazard(); jb = 1;
    tick();
    n_cmp++; if (fa_1 !== 2'd0 || fb_1 !== 2'd0) begin n_err++;
      $display("FAIL reset_fwd got %0d/%0d want 0/0", fa_1, fb_1); end
    n_cmp++; if ({pc_1, ifw_1, bub_1, iff_1, exf_1} !== 5'b11000) begin n_err++;
      $display("FAIL reset_ctrl got %b want 11000", {pc_1, ifw_1, bub_1, iff_1, exf_1}); end
    n_cmp++; if (sc_1 !== 16'd0 || fc_1 !== 16'd0) begin n_err++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", sc_1, fc_1); end
    clear_inputs();
  endtask

  task automatic test_forwarding();
    do_reset();
    ex_rs = 3; ex_rt = 3; mem_wr = 3; mem_rw = 1; wb_wr = 3; wb_rw = 1; #1;
    n_cmp++; if (fa_1 !== 2'd2 || fb_1 !== 2'd2) begin n_err++;
      $display("FAIL fwd_mem got %0d/%0d want 2/2", fa_1, fb_1); end
    mem_rw = 0; #1;
    n_cmp++; if (fa_1 !== 2'd1 || fb_1 !== 2'd1) begin n_err++;
      $display("FAIL fwd_wb got %0d/%0d want 1/1", fa_1, fb_1); end
    mem_rw = 1; mem_wr = 0; wb_wr = 0; #1;
    n_cmp++; if (fa_1 !== 2'd0 || fb_1 !== 2'd0) begin n_err++;
      $display("FAIL fwd_zero got %0d/%0d want 0/0", fa_1, fb_1); end
    ex_rs = 3; ex_rt = 5; mem_wr = 5; wb_wr = 3; #1;
    n_cmp++; if (fa_1 !== 2'd1 || fb_1 !== 2'd2) begin n_err++;
      $display("FAIL fwd_split got %0d/%0d want 1/2", fa_1, fb_1); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    set_hazard(); #1;
    n_cmp++; if ({pc_1, ifw_1, bub_1} !== 3'b001 || {pc_3, bub_3} !== 2'b01) begin n_err++;
      $display("FAIL lu_first got s1=%b s3=%b want 001/01", {pc_1, ifw_1, bub_1}, {pc_3, bub_3}); end
    tick(); clr_hazard(); #1;
    n_cmp++; if (pc_1 !== 1'b1 || bub_1 !== 1'b0 || sc_1 !== 16'd1) begin n_err++;
      $display("FAIL lu_s1_resume got pc=%b bub=%b sc=%0d want 1/0/1", pc_1, bub_1, sc_1); end
    n_cmp++; if (pc_3 !== 1'b0 || bub_3 !== 1'b1) begin n_err++;
      $display("FAIL lu_s3_c1 got pc=%b bub=%b want 0/1", pc_3, bub_3); end
    tick();
    n_cmp++; if (pc_3 !== 1'b0 || bub_3 !== 1'b1) begin n_err++;
      $display("FAIL lu_s3_c2 got pc=%b bub=%b want 0/1", pc_3, bub_3); end
    tick();
    n_cmp++; if (pc_3 !== 1'b1 || bub_3 !== 1'b0 || sc_3 !== 16'd3) begin n_err++;
      $display("FAIL lu_s3_end got pc=%b bub=%b sc=%0d want 1/0/3", pc_3, bub_3, sc_3); end
    n_cmp++; if (sc_1 !== 16'd1) begin n_err++;
      $display("FAIL lu_s1_count got %0d want 1", sc_1); end
  endtask

  task automatic test_redirect();
    do_reset();
    set_hazard(); jb = 1; #1;
    n_cmp++; if ({iff_1, exf_1, bub_1, pc_1} !== 4'b1101) begin n_err++;
      $display("FAIL redir_flush got %b want 1101", {iff_1, exf_1, bub_1, pc_1}); end
    tick(); jb = 0; #1;
    n_cmp++; if ({iff_1, bub_1, pc_1} !== 3'b001 || fc_1 !== 16'd1) begin n_err++;
      $display("FAIL redir_mask got %b fc=%0d want 001/1", {iff_1, bub_1, pc_1}, fc_1); end
    tick();
    n_cmp++; if (bub_1 !== 1'b1) begin n_err++;
      $display("FAIL redir_after got bub=%b want 1", bub_1); end
    clr_hazard();
  endtask

  task automatic test_back_to_back();
    do_reset();
    jb = 1; #1;
    n_cmp++; if (iff_1 !== 1'b1 || exf_1 !== 1'b1) begin n_err++;
      $display("FAIL b2b_first got %b%b want 11", iff_1, exf_1); end
    tick();
    n_cmp++; if (iff_1 !== 1'b1 || exf_1 !== 1'b1 || fc_1 !== 16'd1) begin n_err++;
      $display("FAIL b2b_second got %b%b fc=%0d want 11/1", iff_1, exf_1, fc_1); end
    tick(); jb = 0; #1;
    n_cmp++; if (iff_1 !== 1'b0 || fc_1 !== 16'd2) begin n_err++;
      $display("FAIL b2b_end got flush=%b fc=%0d want 0/2", iff_1, fc_1); end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    set_hazard(); tick(); clr_hazard(); jb = 1; #1;
    n_cmp++; if ({iff_3, exf_3, bub_3, pc_3} !== 4'b1101) begin n_err++;
      $display("FAIL stall_redir got %b want 1101", {iff_3, exf_3, bub_3, pc_3}); end
    tick(); jb = 0; #1;
    n_cmp++; if (bub_3 !== 1'b0 || fc_3 !== 16'd1 || sc_3 !== 16'd1) begin n_err++;
      $display("FAIL stall_redir_after got bub=%b fc=%0d sc=%0d want 0/1/1", bub_3, fc_3, sc_3); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_hazard(); tick(); clr_hazard(); #1;
    n_cmp++; if (bub_3 !== 1'b1) begin n_err++;
      $display("FAIL mid_pre got bub=%b want 1", bub_3); end
    rst = 1; #1;
    n_cmp++; if (pc_3 !== 1'b1 || bub_3 !== 1'b0 || sc_3 !== 16'd0) begin n_err++;
      $display("FAIL mid_reset got pc=%b bub=%b sc=%0d want 1/0/0", pc_3, bub_3, sc_3); end
    tick(); rst = 0; #1;
    n_cmp++; if (pc_3 !== 1'b1 || bub_3 !== 1'b0) begin n_err++;
      $display("FAIL mid_release got pc=%b bub=%b want 1/0", pc_3, bub_3); end
    tick();
    n_cmp++; if (bub_3 !== 1'b0 || sc_3 !== 16'd0) begin n_err++;
      $display("FAIL mid_run got bub=%b sc=%0d want 0/0", bub_3, sc_3); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_hazard();
    repeat (3) tick();
    n_cmp++; if (sc_s !== 2'd3) begin n_err++;
      $display("FAIL sat_full got %0d want 3", sc_s); end
    repeat (2) tick();
    clr_hazard(); #1;
    n_cmp++; if (sc_s !== 2'd3 || sc_1 !== 16'd5) begin n_err++;
      $display("FAIL sat_hold got %0d/%0d want 3/5", sc_s, sc_1); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect();
    test_back_to_back();
    test_stall_redirect();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
